// File: rtl/node_pkg.sv
// Shared definitions for the fully-connected node family: activation modes,
// node state encoding and width helpers.
package node_pkg;
    localparam int ACT_RELU   = 0;
    localparam int ACT_LINEAR = 1;

    typedef enum logic [1:0] {IDLE, MAC, ACT, OUT} state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    function automatic int acc_width(input int dw, input int ww, input int n_in, input int bias_shl);
        return dw + ww + clog2(n_in + 1) + bias_shl + 1;
    endfunction
endpackage

// File: rtl/node_act_sat.sv
// Fixed-point rescale (arithmetic shift, floor) followed by ReLU or linear
// activation with saturation to the output width.
module node_act_sat
    import node_pkg::*;
#(
    parameter int ACCW     = 36,
    parameter int FRAC     = 13,
    parameter int OW       = 16,
    parameter int ACT_MODE = ACT_RELU
) (
    input  logic signed [ACCW-1:0] i_acc,
    output logic        [OW-1:0]   o_data
);
    localparam logic signed [ACCW-1:0] RELU_MAX = {{(ACCW-OW){1'b0}}, {OW{1'b1}}};
    localparam logic signed [ACCW-1:0] LIN_MAX  = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] LIN_MIN  = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    function automatic logic [OW-1:0] sat_relu(input logic signed [ACCW-1:0] r);
        if (r[ACCW-1]) return '0;
        if (r > RELU_MAX) return '1;
        return r[OW-1:0];
    endfunction

    function automatic logic [OW-1:0] sat_lin(input logic signed [ACCW-1:0] r);
        if (r > LIN_MAX) return {1'b0, {(OW-1){1'b1}}};
        if (r < LIN_MIN) return {1'b1, {(OW-1){1'b0}}};
        return r[OW-1:0];
    endfunction

    logic signed [ACCW-1:0] w_shifted;

    assign w_shifted = i_acc >>> FRAC;
    assign o_data    = (ACT_MODE == ACT_LINEAR) ? sat_lin(w_shifted) : sat_relu(w_shifted);
endmodule

// File: rtl/node_mac_seq.sv
// Fully-connected neuron node: bias + dot product over N_IN cycles on one
// shared MAC, then rescale/activate, with valid/ready on both sides.
module node_mac_seq
    import node_pkg::*;
#(
    parameter int N_IN     = 30,
    parameter int DW       = 16,
    parameter int WW       = 16,
    parameter int OW       = 16,
    parameter int FRAC     = 13,
    parameter int BIAS_SHL = 0,
    parameter int ACT_MODE = ACT_RELU,
    parameter logic [(N_IN+1)*WW-1:0] W_INIT = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_IN*DW-1:0]         act_in,
    input  logic                       w_we,
    input  logic [clog2(N_IN+1)-1:0]   w_addr,
    input  logic signed [WW-1:0]       w_data,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OW-1:0]              out_data
);
    localparam int AW   = clog2(N_IN + 1);
    localparam int IW   = (N_IN > 1) ? clog2(N_IN) : 1;
    localparam int ACCW = acc_width(DW, WW, N_IN, BIAS_SHL);
    localparam int PW   = DW + WW;

    state_e                 r_state;
    logic signed [DW-1:0]   r_act [N_IN];
    logic signed [WW-1:0]   r_w [N_IN];
    logic signed [WW-1:0]   r_bias;
    logic signed [ACCW-1:0] r_acc;
    logic [IW-1:0]          r_idx;
    logic                   r_out_valid;
    logic [OW-1:0]          r_out_data;

    logic                   w_idle;
    logic                   w_accept;
    logic                   w_wr_ok;
    logic                   w_wr_bias;
    logic signed [WW-1:0]   w_bias_sel;
    logic signed [ACCW-1:0] w_bias_acc;
    logic signed [PW-1:0]   w_prod;
    logic [OW-1:0]          w_act_data;

    assign w_idle    = (r_state == IDLE);
    assign w_accept  = w_idle && in_valid;
    assign w_wr_ok   = w_idle && w_we && (w_addr <= AW'(N_IN));
    assign w_wr_bias = w_wr_ok && (w_addr == AW'(N_IN));
    // A bias write landing on the accepting edge must already seed the accumulator.
    assign w_bias_sel = w_wr_bias ? w_data : r_bias;
    assign w_bias_acc = {{(ACCW-WW){w_bias_sel[WW-1]}}, w_bias_sel} << BIAS_SHL;
    assign w_prod     = r_act[r_idx] * r_w[r_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_IN; i++) r_w[i] <= W_INIT[i*WW +: WW];
            r_bias <= W_INIT[N_IN*WW +: WW];
        end else if (w_wr_ok) begin
            if (w_wr_bias) r_bias <= w_data;
            else           r_w[w_addr[IW-1:0]] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < N_IN; i++) r_act[i] <= act_in[i*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_acc   <= w_bias_acc;
                        r_idx   <= '0;
                        r_state <= MAC;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + {{(ACCW-PW){w_prod[PW-1]}}, w_prod};
                    r_idx <= r_idx + IW'(1);
                    if (r_idx == IW'(N_IN - 1)) r_state <= ACT;
                end
                ACT: begin
                    r_out_data  <= w_act_data;
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    node_act_sat #(
        .ACCW     (ACCW),
        .FRAC     (FRAC),
        .OW       (OW),
        .ACT_MODE (ACT_MODE)
    ) u_act_sat (
        .i_acc  (r_acc),
        .o_data (w_act_data)
    );

    assign in_ready  = w_idle;
    assign busy      = !w_idle;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
endmodule
